lock_code_writer: RTL

Keypad-side front end for the `LOCK` block: collects 4-bit keypad digits into a shadow code register and commits a complete code by driving `lockBuffer` and pulsing `readLock`. Sits between the keypad decoder and `LOCK`, owning everything on the write side of the `readLock`/`lockBuffer` interface. Partial entries are discarded on error, clear or timeout.

---
 rtl/lock_pkg.sv | 18 +
 rtl/lock_entry_timer.sv | 27 ++
 rtl/lock_code_writer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared constants and state type for the keypad-side writer of the LOCK block.
package lock_pkg;

   localparam int         LOCK_W    = 32;
   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      COMMIT = 2'd2
   } lock_wr_state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'h9;
   endfunction

endpackage

// File: rtl/lock_entry_timer.sv
// Idle counter for the entry window: cleared on load, counts idle cycles,
// flags the cycle whose increment would reach TIMEOUT.
module lock_entry_timer #(
   parameter int TIMEOUT = 1000,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rstN,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)      r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + TW'(1);
   end

   // Expiry is seen on the edge that moves the count onto TIMEOUT.
   assign o_expired = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/lock_code_writer.sv
// Collects keypad digits into a shadow code and commits full codes to LOCK
// via lockBuffer/readLock; partial codes are dropped on error, clear or timeout.
module lock_code_writer
   import lock_pkg::*;
#(
   parameter int DIGITS  = 8,
   parameter int DIGIT_W = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              keyValid,
   input  logic [DIGIT_W-1:0] keyCode,
   output logic              keyReady,
   output logic              readLock,
   output logic [LOCK_W-1:0] lockBuffer,
   output logic              entryActive,
   output logic              entryError
);

   localparam int            CW   = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);

   lock_wr_state_t    r_state;
   logic [LOCK_W-1:0] r_shadow;
   logic [CW-1:0]     r_count;
   logic              r_keyReady;
   logic              r_readLock;
   logic [LOCK_W-1:0] r_lockBuffer;
   logic              r_entryActive;
   logic              r_entryError;

   logic w_acc;
   logic w_digit;
   logic w_full;
   logic w_expired;
   logic w_timer_clr;
   logic w_timer_inc;

   assign w_acc       = keyValid && r_keyReady;
   assign w_digit     = is_digit(keyCode);
   assign w_full      = (r_count == FULL);
   assign w_timer_clr = w_acc || (r_state != ENTRY);
   assign w_timer_inc = (r_state == ENTRY) && !w_acc;

   lock_entry_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rstN      (rstN),
      .i_clr     (w_timer_clr),
      .i_inc     (w_timer_inc),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state       <= IDLE;
         r_shadow      <= '0;
         r_count       <= '0;
         r_keyReady    <= 1'b1;
         r_readLock    <= 1'b0;
         r_lockBuffer  <= '0;
         r_entryActive <= 1'b0;
         r_entryError  <= 1'b0;
      end else begin
         r_readLock   <= 1'b0;
         r_entryError <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_acc && w_digit) begin
                  r_shadow      <= {{(LOCK_W-DIGIT_W){1'b0}}, keyCode};
                  r_count       <= CW'(1);
                  r_state       <= ENTRY;
                  r_entryActive <= 1'b1;
               end else if (w_acc && keyCode == KEY_ENTER) begin
                  r_entryError <= 1'b1;
               end
            end
            ENTRY: begin
               if (w_acc) begin
                  if (w_digit) begin
                     if (w_full) begin
                        r_entryError <= 1'b1;
                     end else begin
                        r_shadow <= {r_shadow[LOCK_W-DIGIT_W-1:0], keyCode};
                        r_count  <= r_count + CW'(1);
                     end
                  end else if (keyCode == KEY_ENTER && w_full) begin
                     r_lockBuffer  <= r_shadow;
                     r_readLock    <= 1'b1;
                     r_keyReady    <= 1'b0;
                     r_entryActive <= 1'b0;
                     r_state       <= COMMIT;
                  end else if (keyCode == KEY_ENTER || keyCode == KEY_CLEAR) begin
                     r_entryError  <= (keyCode == KEY_ENTER);
                     r_shadow      <= '0;
                     r_count       <= '0;
                     r_entryActive <= 1'b0;
                     r_state       <= IDLE;
                  end
               end else if (w_expired) begin
                  r_entryError  <= 1'b1;
                  r_shadow      <= '0;
                  r_count       <= '0;
                  r_entryActive <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            COMMIT: begin
               r_shadow   <= '0;
               r_count    <= '0;
               r_keyReady <= 1'b1;
               r_state    <= IDLE;
            end
            default: begin
               r_state       <= IDLE;
               r_keyReady    <= 1'b1;
               r_entryActive <= 1'b0;
            end
         endcase
      end
   end

   assign keyReady    = r_keyReady;
   assign readLock    = r_readLock;
   assign lockBuffer  = r_lockBuffer;
   assign entryActive = r_entryActive;
   assign entryError  = r_entryError;

endmodule
